led_count_ctrl: RTL and testbench

- Run/pause/step controller for the 4-bit LED counter datapath.
- Owns the one-second tick timer and the counter register.
- Sequences the counter from debounced single-cycle button pulses: start/stop, single step, direction toggle, clear.
- Drives LEDs directly through `count` and exposes status for other board logic.

---
 rtl/led_count_ctrl.sv | 73 +++++++
 tb/tb_led_count_ctrl.sv | 95 +++++++++
 2 files changed

// File: rtl/led_count_ctrl.sv
// led_count_ctrl: run/pause/step controller owning the tick timer and LED counter.
module led_count_ctrl #(
    parameter int CYCLES_PER_TICK = 125000000,
    parameter int TIMER_WIDTH     = 27,
    parameter int CNT_WIDTH       = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_stop,
    input  logic                 step,
    input  logic                 dir_toggle,
    input  logic                 clear,
    input  logic                 wrap_en,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 running,
    output logic                 dir_down,
    output logic                 tick
);
    typedef enum logic {PAUSED, RUN} state_t;
    localparam logic [TIMER_WIDTH-1:0] TMAX = TIMER_WIDTH'(CYCLES_PER_TICK - 1);
    localparam logic [CNT_WIDTH-1:0]   CMAX = '1;
    state_t                 state_q, state_d;
    logic [TIMER_WIDTH-1:0] timer_q, timer_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d;
    logic                   dir_q, dir_d, tick_q, tick_d;
    logic                   update, at_limit;
    logic [CNT_WIDTH-1:0]   nxt;
    always_comb begin
        update   = state_q == RUN ? timer_q == TMAX : step;
        at_limit = dir_q ? count_q == '0 : count_q == CMAX;
        nxt      = dir_q ? count_q - CNT_WIDTH'(1) : count_q + CNT_WIDTH'(1);
        state_d  = state_q;
        timer_d  = state_q == RUN && timer_q != TMAX ? timer_q + TIMER_WIDTH'(1) : '0;
        count_d  = count_q;
        dir_d    = dir_q ^ dir_toggle;
        tick_d   = 1'b0;
        if (clear) begin
            count_d = '0;
            timer_d = '0;
        end else if (start_stop) begin
            state_d = state_q == RUN ? PAUSED : RUN;
            timer_d = '0;
        end else if (update) begin
            // saturating at a limit stops the run instead of producing a tick
            if (at_limit && !wrap_en) begin
                state_d = PAUSED;
                timer_d = '0;
            end else begin
                count_d = nxt;
                tick_d  = 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= PAUSED;
            timer_q <= '0;
            count_q <= '0;
            dir_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            count_q <= count_d;
            dir_q   <= dir_d;
            tick_q  <= tick_d;
        end
    end
    assign count    = count_q;
    assign running  = state_q == RUN;
    assign dir_down = dir_q;
    assign tick     = tick_q;
endmodule

// File: tb/tb_led_count_ctrl.sv
// tb_led_count_ctrl: randomized scoreboard bench against an integer reference model.
module tb_led_count_ctrl;
    localparam int P = 4;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0, start_stop = 1'b0, step = 1'b0, dir_toggle = 1'b0, clear = 1'b0, wrap_en = 1'b1;
    logic [3:0] count;
    logic       running, dir_down, tick;
    int         checks = 0, errors = 0;
    typedef struct packed {logic [3:0] c; logic r; logic d; logic t;} exp_t;
    exp_t       sb[$];
    int         m_cnt = 0, m_ph = 0;
    bit         m_run = 0, m_dir = 0, m_tick = 0;
    led_count_ctrl #(.CYCLES_PER_TICK(P), .TIMER_WIDTH(2), .CNT_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start_stop(start_stop), .step(step), .dir_toggle(dir_toggle),
        .clear(clear), .wrap_en(wrap_en), .count(count), .running(running), .dir_down(dir_down), .tick(tick)
    );
    always #5 clk = ~clk;
    // Reference: m_ph counts cycles elapsed since the run (or last update) began.
    task automatic drive(input logic rn, input logic ss, input logic st, input logic tg, input logic cl, input logic we);
        int n;
        bit fire;
        @(negedge clk);
        rst_n = rn; start_stop = ss; step = st; dir_toggle = tg; clear = cl; wrap_en = we;
        m_tick = 0;
        if (!rn) begin
            m_cnt = 0; m_ph = 0; m_run = 0; m_dir = 0;
        end else begin
            fire = m_run ? (m_ph == P - 1) : st;
            if (cl) begin
                m_cnt = 0; m_ph = 0;
            end else if (ss) begin
                m_run = !m_run; m_ph = 0;
            end else if (fire) begin
                n = m_dir ? m_cnt - 1 : m_cnt + 1;
                m_ph = 0;
                if (n < 0 || n > 15) begin
                    if (we) begin m_cnt = (n + 16) % 16; m_tick = 1; end
                    else m_run = 0;
                end else begin
                    m_cnt = n; m_tick = 1;
                end
            end else if (m_run) m_ph++;
            if (tg) m_dir = !m_dir;
        end
        sb.push_back({4'(m_cnt), m_run, m_dir, m_tick});
    endtask
    task automatic cmp(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                cmp("count", int'(count), int'(e.c));
                cmp("running", int'(running), int'(e.r));
                cmp("dir_down", int'(dir_down), int'(e.d));
                cmp("tick", int'(tick), int'(e.t));
            end
        end
    end
    initial begin
        logic we;
        we = 1'b1;
        repeat (2) drive(0, 0, 0, 0, 0, 1);
        drive(1, 1, 0, 0, 0, 1);
        repeat (14) drive(1, 0, 0, 0, 0, 1);
        drive(1, 1, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 1, 1);
        drive(1, 0, 0, 1, 0, 1);
        drive(1, 0, 1, 0, 0, 1);
        drive(1, 0, 1, 0, 0, 0);
        drive(1, 0, 1, 1, 0, 0);
        drive(1, 1, 0, 0, 0, 0);
        repeat (80) drive(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 49) == 0) we = ~we;
            drive($urandom_range(0, 199) != 0, $urandom_range(0, 19) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 24) == 0, $urandom_range(0, 59) == 0, we);
        end
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain pending %0d expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
